// File: rtl/iter_multiplier_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Holds the state encoding, default operand width and iteration count width.
package iter_multiplier_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int COUNT_W   = $clog2(DEF_WIDTH);

    // Encoding 2'd3 is unused and falls back to IDLE in the next-state logic
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A new operation may only be launched from these states
    function automatic logic can_accept(input state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/iter_multiplier_if.sv
// Request/response bundle between the operand-select control and the multiplier.
// The control side drives operands and start; the multiplier returns status and product.
interface iter_multiplier_if
    import iter_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;

    modport master (
        output start, sgn, a, b,
        input  busy, done, product_hi, product_lo
    );

    modport slave (
        input  start, sgn, a, b,
        output busy, done, product_hi, product_lo
    );
endinterface

// File: rtl/iter_multiplier_mag_conv.sv
// Combinational two's-complement sign/magnitude conversion.
// SIGNED_IN=1 negates negative signed inputs; SIGNED_IN=0 negates whenever sgn is set.
module mag_conv #(
    parameter int W         = 16,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic [W-1:0] din,
    input  logic         sgn,
    output logic [W-1:0] magnitude,
    output logic         neg
);
    assign neg = sgn & (SIGNED_IN ? din[W-1] : 1'b1);

    // The most negative value maps onto itself, which reads correctly as unsigned
    assign magnitude = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/iter_multiplier.sv
// Multi-cycle shift-add multiplier: one partial-product iteration per clock,
// WIDTH iterations per operation, signed or unsigned operands.
module iter_multiplier
    import iter_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    iter_multiplier_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [CW-1:0]      count_reg;
    logic               sign_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] product_reg;

    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_shift;
    logic [WIDTH-1:0]   mplier_shift;
    logic [2*WIDTH-1:0] full_next;
    logic [2*WIDTH-1:0] prod_mag;
    logic               prod_neg;

    logic [WIDTH-1:0]   op_raw [2];
    logic [WIDTH-1:0]   op_mag [2];
    logic               op_neg [2];

    assign op_raw[0] = bus.a;
    assign op_raw[1] = bus.b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op_conv
            mag_conv #(
                .W         (WIDTH),
                .SIGNED_IN (1'b1)
            ) u_conv (
                .din       (op_raw[gi]),
                .sgn       (bus.sgn),
                .magnitude (op_mag[gi]),
                .neg       (op_neg[gi])
            );
        end
    endgenerate

    // One iteration: conditional add into the upper half, then shift {carry, acc, mplier}
    always_comb begin
        sum          = {1'b0, acc_reg} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
        acc_shift    = sum[WIDTH:1];
        mplier_shift = {sum[0], mplier_reg[WIDTH-1:1]};
        full_next    = {acc_shift, mplier_shift};
    end

    // Same negate path, used unconditionally on the latched result sign
    mag_conv #(
        .W         (2 * WIDTH),
        .SIGNED_IN (1'b0)
    ) u_prod_conv (
        .din       (full_next),
        .sgn       (sign_reg),
        .magnitude (prod_mag),
        .neg       (prod_neg)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_iter  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count_reg == LAST) begin
                    last_iter  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                accept     = bus.start;
                state_next = bus.start ? BUSY : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            sign_reg    <= 1'b0;
            mcand_reg   <= '0;
            acc_reg     <= '0;
            mplier_reg  <= '0;
            product_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept && can_accept(state_reg)) begin
                mcand_reg  <= op_mag[0];
                mplier_reg <= op_mag[1];
                acc_reg    <= '0;
                sign_reg   <= op_neg[0] ^ op_neg[1];
                count_reg  <= '0;
            end else if (state_reg == BUSY) begin
                acc_reg    <= acc_shift;
                mplier_reg <= mplier_shift;
                count_reg  <= count_reg + CW'(1);
                if (last_iter) begin
                    product_reg <= prod_neg ? prod_mag : full_next;
                end
            end
        end
    end

    assign bus.busy       = (state_reg == BUSY);
    assign bus.done       = (state_reg == DONE);
    assign bus.product_hi = product_reg[2*WIDTH-1:WIDTH];
    assign bus.product_lo = product_reg[WIDTH-1:0];

endmodule
